// File: rtl/icache_refill.sv
// icache_refill: I-cache miss refill engine (line burst or single-word SUC).
// Define ICACHE_REFILL_CRIT_FIRST_EN for critical-word-first wrapping bursts.
module icache_refill #(
  parameter int offset_width = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          miss_valid,
  input  logic [31:0]                   miss_paddr,
  input  logic                          miss_SUC,
  output logic                          miss_ready,
  output logic                          mem_rd_req,
  output logic                          mem_rd_type,
  output logic [31:0]                   mem_rd_addr,
  input  logic                          mem_rd_ready,
  input  logic                          mem_ret_valid,
  input  logic                          mem_ret_last,
  input  logic [31:0]                   mem_ret_data,
  output logic                          refill_valid,
  output logic [31:0]                   refill_addr,
  output logic [32*(1<<offset_width)-1:0] refill_data,
  output logic                          refill_SUC,
  input  logic                          refill_ack,
  input  logic                          flush
);

  localparam int N  = 1 << offset_width;
  localparam int LW = 32 * N;

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    cancel_q, cancel_d;
  logic [offset_width-1:0] cnt_q, cnt_d;
  logic [offset_width-1:0] start_q, start_d;
  logic [31:0]             paddr_q, paddr_d;
  logic                    suc_q, suc_d;
  logic [LW-1:0]           data_q, data_d;
  logic                    req_q, req_d;
  logic                    type_q, type_d;
  logic [31:0]             raddr_q, raddr_d;
  logic                    valid_q, valid_d;

  logic [offset_width-1:0] miss_word;
  logic [offset_width-1:0] slot;
  logic [31:0]             word_addr;
  logic [31:0]             line_addr;
  logic [31:0]             line_start;
  logic [offset_width-1:0] line_first;

  assign miss_word = miss_paddr[offset_width+1:2];
  assign word_addr = {miss_paddr[31:2], 2'b00};
  assign line_addr = {miss_paddr[31:offset_width+2],
                      {(offset_width+2){1'b0}}};
  assign slot      = start_q + cnt_q;

`ifdef ICACHE_REFILL_CRIT_FIRST_EN
  assign line_start = word_addr;
  assign line_first = miss_word;
`else
  assign line_start = line_addr;
  assign line_first = '0;
`endif

  assign miss_ready   = (state_q == IDLE);
  assign mem_rd_req   = req_q;
  assign mem_rd_type  = type_q;
  assign mem_rd_addr  = raddr_q;
  assign refill_valid = valid_q;
  assign refill_addr  = paddr_q;
  assign refill_data  = data_q;
  assign refill_SUC   = suc_q;

  // next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    paddr_d  = paddr_q;
    suc_d    = suc_q;
    data_d   = data_q;
    req_d    = req_q;
    type_d   = type_q;
    raddr_d  = raddr_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          paddr_d  = miss_paddr;
          suc_d    = miss_SUC;
          cnt_d    = '0;
          cancel_d = 1'b0;
          req_d    = 1'b1;
          type_d   = ~miss_SUC;
          raddr_d  = miss_SUC ? word_addr : line_start;
          start_d  = miss_SUC ? miss_word : line_first;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (flush) cancel_d = 1'b1;
        if (mem_rd_ready) begin
          req_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (flush) cancel_d = 1'b1;
        if (mem_ret_valid) begin
          for (int i = 0; i < N; i++) begin
            if (slot == i[offset_width-1:0])
              data_d[32*i +: 32] = mem_ret_data;
          end
          cnt_d = cnt_q + 1'b1;
          if (mem_ret_last) begin
            if (cancel_q || flush) begin
              cancel_d = 1'b0;
              state_d  = IDLE;
            end else begin
              valid_d = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (flush || refill_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      cnt_q    <= '0;
      start_q  <= '0;
      paddr_q  <= '0;
      suc_q    <= 1'b0;
      data_q   <= '0;
      req_q    <= 1'b0;
      type_q   <= 1'b0;
      raddr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      paddr_q  <= paddr_d;
      suc_q    <= suc_d;
      data_q   <= data_d;
      req_q    <= req_d;
      type_q   <= type_d;
      raddr_q  <= raddr_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed vectors against a transaction-level refill model.
// Honours ICACHE_REFILL_CRIT_FIRST_EN when the design is built with it.
module tb_icache_refill;

  localparam int N  = 4;
  localparam int LW = 32 * N;

  logic          clk = 1'b0;
  logic          rstn;
  logic          miss_valid;
  logic [31:0]   miss_paddr;
  logic          miss_SUC;
  logic          miss_ready;
  logic          mem_rd_req;
  logic          mem_rd_type;
  logic [31:0]   mem_rd_addr;
  logic          mem_rd_ready;
  logic          mem_ret_valid;
  logic          mem_ret_last;
  logic [31:0]   mem_ret_data;
  logic          refill_valid;
  logic [31:0]   refill_addr;
  logic [LW-1:0] refill_data;
  logic          refill_SUC;
  logic          refill_ack;
  logic          flush;

  int nvec = 0;
  int nmis = 0;

  icache_refill #(.offset_width(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .miss_valid   (miss_valid),
    .miss_paddr   (miss_paddr),
    .miss_SUC     (miss_SUC),
    .miss_ready   (miss_ready),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_type  (mem_rd_type),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_ret_valid(mem_ret_valid),
    .mem_ret_last (mem_ret_last),
    .mem_ret_data (mem_ret_data),
    .refill_valid (refill_valid),
    .refill_addr  (refill_addr),
    .refill_data  (refill_data),
    .refill_SUC   (refill_SUC),
    .refill_ack   (refill_ack),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for miss, 1 asking bus, 2 collecting beats, 3 holding line
  int          ph = 0;
  bit          m_cancel = 0;
  logic [31:0] m_paddr = '0;
  bit          m_suc = 0;
  int          m_beats = 0;
  logic [31:0] m_words [N];

  function automatic logic [31:0] exp_rd_addr(logic [31:0] a, bit s);
    if (s) return {a[31:2], 2'b00};
`ifdef ICACHE_REFILL_CRIT_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:4], 4'h0};
`endif
  endfunction

  function automatic int first_word(logic [31:0] a, bit s);
    if (s) return int'(a[3:2]);
`ifdef ICACHE_REFILL_CRIT_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] l;
    for (int i = 0; i < N; i++) l[32*i +: 32] = m_words[i];
    return l;
  endfunction

  // model advances on the same edges as the design
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph = 0; m_cancel = 0; m_paddr = '0; m_suc = 0; m_beats = 0;
      for (int i = 0; i < N; i++) m_words[i] = '0;
    end else begin
      case (ph)
        0: if (miss_valid) begin
          m_paddr = miss_paddr; m_suc = miss_SUC;
          m_beats = 0; m_cancel = 0; ph = 1;
        end
        1: begin
          if (flush) m_cancel = 1;
          if (mem_rd_ready) ph = 2;
        end
        2: begin
          if (flush) m_cancel = 1;
          if (mem_ret_valid) begin
            m_words[(first_word(m_paddr, m_suc) + m_beats) % N] = mem_ret_data;
            m_beats++;
            if (mem_ret_last) ph = m_cancel ? 0 : 3;
          end
        end
        default: if (flush || refill_ack) ph = 0;
      endcase
    end
  end

  // compare process on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_refill_valid", LW'(refill_valid), '0);
      chk("rst_rd_req", LW'(mem_rd_req), '0);
      chk("rst_refill_data", refill_data, '0);
      chk("rst_refill_addr", LW'(refill_addr), '0);
      chk("rst_refill_suc", LW'(refill_SUC), '0);
    end else begin
      chk("miss_ready", LW'(miss_ready), LW'(ph == 0));
      chk("rd_req", LW'(mem_rd_req), LW'(ph == 1));
      chk("refill_valid", LW'(refill_valid), LW'(ph == 3));
      if (ph == 1) begin
        chk("rd_type", LW'(mem_rd_type), LW'(!m_suc));
        chk("rd_addr", LW'(mem_rd_addr), LW'(exp_rd_addr(m_paddr, m_suc)));
      end
      if (ph == 3) begin
        chk("refill_data", refill_data, exp_line());
        chk("refill_addr", LW'(refill_addr), LW'(m_paddr));
        chk("refill_suc", LW'(refill_SUC), LW'(m_suc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(logic [31:0] a, bit s);
    miss_valid = 1'b1; miss_paddr = a; miss_SUC = s;
    cyc();
    miss_valid = 1'b0;
  endtask

  task automatic handshake(int stall);
    repeat (stall) cyc();
    mem_rd_ready = 1'b1;
    cyc();
    mem_rd_ready = 1'b0;
  endtask

  task automatic beat(logic [31:0] d, bit last);
    mem_ret_valid = 1'b1; mem_ret_data = d; mem_ret_last = last;
    cyc();
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
  endtask

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;

  initial begin
    logic [LW-1:0] line_dcba;
    logic [31:0]   stall_addr;
    line_dcba = {WD, WC, WB, WA};
`ifdef ICACHE_REFILL_CRIT_FIRST_EN
    stall_addr = 32'h4000_0024;
`else
    stall_addr = 32'h4000_0020;
`endif
    rstn = 1'b0; miss_valid = 0; miss_paddr = '0; miss_SUC = 0;
    mem_rd_ready = 0; mem_ret_valid = 0; mem_ret_last = 0;
    mem_ret_data = '0; refill_ack = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("reset_miss_ready", LW'(miss_ready), LW'(1'b1));
    chk("reset_refill_valid", LW'(refill_valid), '0);

    // line miss
    accept(32'h1C00_0018, 1'b0);
`ifdef ICACHE_REFILL_CRIT_FIRST_EN
    chk("line_addr_lit", LW'(mem_rd_addr), LW'(32'h1C00_0018));
`else
    chk("line_addr_lit", LW'(mem_rd_addr), LW'(32'h1C00_0010));
`endif
    chk("line_type_lit", LW'(mem_rd_type), LW'(1'b1));
    handshake(0);
`ifdef ICACHE_REFILL_CRIT_FIRST_EN
    beat(WC, 0); beat(WD, 0); beat(WA, 0);
    chk("line_not_yet", LW'(refill_valid), '0);
    beat(WB, 1);
`else
    beat(WA, 0); beat(WB, 0); beat(WC, 0);
    chk("line_not_yet", LW'(refill_valid), '0);
    beat(WD, 1);
`endif
    chk("line_valid_lit", LW'(refill_valid), LW'(1'b1));
    chk("line_data_lit", refill_data, line_dcba);
    cyc();
    chk("line_hold_lit", refill_data, line_dcba);

    // miss offered during ack cycle must wait
    miss_valid = 1'b1; miss_paddr = 32'hBFAF_8004; miss_SUC = 1'b1;
    refill_ack = 1'b1;
    cyc();
    refill_ack = 1'b0;
    chk("ack_no_accept", LW'(miss_ready), LW'(1'b1));

    // SUC single-word miss
    accept(32'hBFAF_8004, 1'b1);
    chk("suc_type_lit", LW'(mem_rd_type), '0);
    chk("suc_addr_lit", LW'(mem_rd_addr), LW'(32'hBFAF_8004));
    handshake(0);
    beat(32'h0000_0055, 1);
    chk("suc_word1_lit", LW'(refill_data[63:32]), LW'(32'h55));
    chk("suc_flag_lit", LW'(refill_SUC), LW'(1'b1));
    refill_ack = 1'b1; cyc(); refill_ack = 1'b0;

    // stray return beat in idle is ignored
    beat(32'hDEAD_BEEF, 1);
    chk("stray_ignored", LW'(refill_data[63:32]), LW'(32'h55));

    // flush mid-burst
    accept(32'h0000_1000, 1'b0);
    handshake(0);
    beat(32'h1, 0); beat(32'h2, 0);
    flush = 1'b1; cyc(); flush = 1'b0;
    beat(32'h3, 0);
    chk("flush_draining", LW'(miss_ready), '0);
    beat(32'h4, 1);
    chk("flush_ready_lit", LW'(miss_ready), LW'(1'b1));
    chk("flush_novalid_lit", LW'(refill_valid), '0);

    // flush during the request handshake
    accept(32'h2000_0004, 1'b0);
    flush = 1'b1; mem_rd_ready = 1'b1;
    cyc();
    flush = 1'b0; mem_rd_ready = 1'b0;
    beat(32'h11, 0); beat(32'h12, 0); beat(32'h13, 0); beat(32'h14, 1);
    chk("reqflush_novalid", LW'(refill_valid), '0);

    // flush with miss in idle: miss wins, then flush in done
    flush = 1'b1;
    accept(32'h3000_0008, 1'b0);
    flush = 1'b0;
    chk("idle_flush_accept", LW'(mem_rd_req), LW'(1'b1));
    handshake(1);
    beat(32'h21, 0); beat(32'h22, 0); beat(32'h23, 0); beat(32'h24, 1);
    chk("done_valid", LW'(refill_valid), LW'(1'b1));
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("done_flush_drop", LW'(refill_valid), '0);

    // bus stall then reset mid-burst
    accept(32'h4000_0024, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", LW'(mem_rd_req), LW'(1'b1));
      chk("stall_addr", LW'(mem_rd_addr), LW'(stall_addr));
      cyc();
    end
    handshake(0);
    beat(32'h31, 0);
    mem_ret_valid = 1'b1; mem_ret_data = 32'h32;
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", LW'(miss_ready), LW'(1'b1));
    chk("arst_req", LW'(mem_rd_req), '0);
    chk("arst_valid", LW'(refill_valid), '0);
    chk("arst_data", refill_data, '0);
    chk("arst_addr", LW'(refill_addr), '0);
    mem_ret_valid = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
    chk("post_rst_idle", LW'(miss_ready), LW'(1'b1));
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
